imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. It fills the same word-indexed store that the fetch path reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Each assembled instruction goes out on the memory write port at consecutive word addresses starting at 0.
- Holds the CPU stalled from load start until the last word is written.

Parameters:
- ADDR_W, 5, word-address width; memory depth = 2**ADDR_W words (default 32)
- DATA_W, 32, instruction width; fixed at 4 bytes, other values unsupported

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE or DONE
- BYTE_IN  in  8  stream byte
- BYTE_VALID  in  1  BYTE_IN valid
- BYTE_READY  out  1  loader can accept a byte this cycle
- IMWA  out  32  word address (word index, not byte address); upper bits zero
- IMWD  out  32  instruction word to write
- IMWE  out  1  write strobe, one cycle per word
- CPU_HOLD  out  1  stall/hold-in-reset request to the core
- DONE  out  1  load complete, held until next START
- ERR  out  1  load aborted, held until next START

Behaviour:
- All outputs are registered.
- Reset (async, RST_N=0): state IDLE. BYTE_READY=0, IMWA=0, IMWD=0, IMWE=0, CPU_HOLD=0, DONE=0, ERR=0. Internal counters cleared.
- Reset mid-load: loader returns to IDLE. Words already written stay in memory; the memory is not cleared.
- Byte transfer occurs on a rising edge where BYTE_VALID && BYTE_READY. BYTE_IN must be stable while valid.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CKSUM (only with the optional feature), DONE.
- IDLE/DONE + START → LEN_LO. Next cycle: CPU_HOLD=1, DONE=0, ERR=0, word_cnt=0, byte_cnt=0.
- LEN_LO: BYTE_READY=1. Accepted byte → N[7:0], go to LEN_HI.
- LEN_HI: BYTE_READY=1. Accepted byte → N[15:8]. Then:
  - N > 2**ADDR_W → IDLE with ERR=1 and CPU_HOLD=0; no writes.
  - N == 0 → DONE (CKSUM first if enabled).
  - Otherwise → DATA.
- DATA: BYTE_READY=1. Byte k (k=0..3) goes into bits [8k+7:8k] of the shift register; first byte is the LSB. On the 4th accepted byte → WRITE.
- WRITE: lasts exactly one cycle.
  - BYTE_READY=0, IMWE=1, IMWA=word_cnt, IMWD=assembled word.
  - Then word_cnt increments. If new word_cnt == N → DONE (or CKSUM); else → DATA with byte_cnt=0.
- DONE: DONE=1, CPU_HOLD=0, BYTE_READY=0.
- Latency: 4th byte accepted at edge t → IMWE high during cycle t+1 → BYTE_READY high again at t+2.
- Stalls: BYTE_VALID low for any number of cycles stalls with no state change.
- START while busy (LEN_LO..CKSUM) is ignored.
- START and reset together: reset wins.
- A full load (N = 2**ADDR_W) writes address 2**ADDR_W-1 last. word_cnt is ADDR_W+1 bits wide so it does not wrap.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- Defined:
  - Loader keeps a running XOR of all data bytes (length bytes excluded).
  - After the last WRITE it enters CKSUM with BYTE_READY=1 and accepts one trailing byte.
  - Match → DONE. Mismatch → IDLE with ERR=1, CPU_HOLD=0, DONE=0. Words already written remain in memory.
  - For N=0 the expected checksum is 0x00.
- Undefined: no CKSUM state and no XOR register; the stream ends with the last data byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding enum (IDLE=0, LEN_LO, LEN_HI, DATA, WRITE, CKSUM, DONE);
  - the BYTES_PER_WORD=4 constant;
  - the LEN_W=16 constant.
- No sub-module is needed. The byte assembler stays inline (a 32-bit shift register plus a 2-bit counter).

Test Plan:
- Reset, START, N=2, bytes 13 00 00 00 93 00 10 00 → IMWE pulses with (IMWA=0, IMWD=0x00000013) then (1, 0x00100093); DONE=1; CPU_HOLD low after the final WRITE.
- N=32 with all words 0xAABBCCDD and random BYTE_VALID gaps → 32 writes at addresses 0..31, no drops or duplicates, DONE=1.
- N=33 (length bytes 21 00) → no IMWE, ERR=1, state IDLE; a following START clears ERR.
- N=0 → DONE=1 two edges after the length bytes, zero writes (CKSUM_EN: trailing byte 00 required).
- RST_N low after 6 data bytes → outputs return to reset values immediately; word 0 already written; a subsequent START plus a full stream completes normally.
- CKSUM_EN, N=1, word 0x04030201, trailing byte 0x04 → DONE=1; trailing byte 0x05 → ERR=1, DONE=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and constants for the instruction
//               memory boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CKSUM  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot-time byte-stream loader that fills the instruction memory
//               with little-endian words; optional trailing XOR checksum
//               enabled by defining IMEM_LOADER_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic [31:0]       IMWA,
    output logic [DATA_W-1:0] IMWD,
    output logic              IMWE,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);

    state_t              r_state;
    state_t              w_next;
    state_t              w_tail;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W:0]     r_word_cnt;
    logic [ADDR_W:0]     w_cnt_inc;
    logic [1:0]          r_byte_cnt;
    logic [DATA_W-9:0]   r_shift;
    logic [ADDR_W-1:0]   r_imwa;
    logic                w_accept;
    logic                w_start_go;
    logic                w_fail;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          r_xor;
`endif

    assign w_accept   = BYTE_VALID && BYTE_READY;
    assign w_start_go = START && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len      = {BYTE_IN, r_len[7:0]};
    assign w_cnt_inc  = r_word_cnt + 1'b1;
    assign IMWA       = {{(32-ADDR_W){1'b0}}, r_imwa};

`ifdef IMEM_LOADER_CKSUM_EN
    assign w_tail = S_CKSUM;
`else
    assign w_tail = S_DONE;
`endif

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_len) > (32'd1 << ADDR_W)) begin
                        w_next = S_IDLE;
                        w_fail = 1'b1;
                    end else if (w_len == '0) begin
                        w_next = w_tail;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_cnt == 2'(BYTES_PER_WORD-1))) w_next = S_WRITE;
            end
            S_WRITE: begin
                // word_cnt is one wider than the address so a full memory does not wrap
                if (LEN_W'(w_cnt_inc) == r_len) w_next = w_tail;
                else                            w_next = S_DATA;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (w_accept) begin
                    if (BYTE_IN == r_xor) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_IDLE;
                        w_fail = 1'b1;
                    end
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_imwa     <= '0;
            IMWD       <= '0;
            IMWE       <= 1'b0;
            BYTE_READY <= 1'b0;
            CPU_HOLD   <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_state    <= w_next;
            BYTE_READY <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                          (w_next == S_DATA)   || (w_next == S_CKSUM);
            CPU_HOLD   <= (w_next != S_IDLE) && (w_next != S_DONE);
            DONE       <= (w_next == S_DONE);
            IMWE       <= (w_next == S_WRITE);

            if (w_start_go) begin
                ERR        <= 1'b0;
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                r_xor      <= '0;
`endif
            end else if (w_fail) begin
                ERR <= 1'b1;
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len[7:0]  <= BYTE_IN;
                    S_LEN_HI: r_len[15:8] <= BYTE_IN;
                    S_DATA: begin
                        r_shift    <= {BYTE_IN, r_shift[DATA_W-9:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        r_xor      <= r_xor ^ BYTE_IN;
`endif
                        if (r_byte_cnt == 2'(BYTES_PER_WORD-1)) begin
                            IMWD   <= {BYTE_IN, r_shift};
                            r_imwa <= r_word_cnt[ADDR_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) r_word_cnt <= w_cnt_inc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard testbench for imem_loader (define
//               IMEM_LOADER_CKSUM_EN to exercise the checksum build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  BYTE_IN = '0;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic [31:0] IMWA;
    logic [31:0] IMWD;
    logic        IMWE;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  run_xor;

    imem_loader #(.ADDR_W(5), .DATA_W(32)) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .IMWA       (IMWA),
        .IMWD       (IMWD),
        .IMWE       (IMWE),
        .CPU_HOLD   (CPU_HOLD),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued word.
    always @(negedge CLK) begin
        if (RST_N && IMWE) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", IMWA, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", IMWA, e[63:32]);
                check_eq("wr_data", IMWD, e[31:0]);
            end
        end
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge CLK);
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        while (!BYTE_READY && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) check_eq("ready_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        BYTE_VALID = 1'b0;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w, input int max_gap);
        exp_q.push_back({32'(addr), w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], max_gap);
            run_xor = run_xor ^ w[8*k +: 8];
        end
    endtask

    task automatic send_len(input logic [15:0] n);
        run_xor = 8'h00;
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_tail(input logic [7:0] flip);
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(run_xor ^ flip, 0);
`else
        if (flip != 8'h00) run_xor = run_xor ^ flip;
`endif
    endtask

    task automatic wait_end(input string tag);
        int t = 0;
        while (!(DONE || ERR) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int wr0;
        repeat (3) @(negedge CLK);
        check_eq("rst_ready", 32'(BYTE_READY), 32'd0);
        check_eq("rst_imwe",  32'(IMWE),       32'd0);
        check_eq("rst_imwa",  IMWA,            32'd0);
        check_eq("rst_imwd",  IMWD,            32'd0);
        check_eq("rst_hold",  32'(CPU_HOLD),   32'd0);
        check_eq("rst_done_err", {30'd0, DONE, ERR}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Two-word load
        pulse_start();
        check_eq("t1_hold", 32'(CPU_HOLD), 32'd1);
        check_eq("t1_ready", 32'(BYTE_READY), 32'd1);
        send_len(16'd2);
        send_word(0, 32'h0000_0013, 0);
        send_word(1, 32'h0010_0093, 0);
        send_tail(8'h00);
        wait_end("t1");
        check_eq("t1_done", 32'(DONE), 32'd1);
        check_eq("t1_err", 32'(ERR), 32'd0);
        check_eq("t1_hold_end", 32'(CPU_HOLD), 32'd0);
        check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Full memory with random valid gaps and an ignored START mid-stream
        pulse_start();
        check_eq("t2_done_clr", 32'(DONE), 32'd0);
        send_len(16'd32);
        for (int i = 0; i < 32; i++) begin
            send_word(i, 32'hAABB_CCDD, 2);
            if (i == 10) pulse_start();
        end
        send_tail(8'h00);
        wait_end("t2");
        check_eq("t2_done", 32'(DONE), 32'd1);
        check_eq("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Oversize length
        wr0 = n_writes;
        pulse_start();
        send_len(16'd33);
        wait_end("t3");
        check_eq("t3_err", 32'(ERR), 32'd1);
        check_eq("t3_done", 32'(DONE), 32'd0);
        check_eq("t3_hold", 32'(CPU_HOLD), 32'd0);
        check_eq("t3_ready", 32'(BYTE_READY), 32'd0);
        check_eq("t3_nowrite", 32'(n_writes - wr0), 32'd0);
        pulse_start();
        check_eq("t3_err_clr", 32'(ERR), 32'd0);

        // Zero-length load (restart from LEN_LO, already started above)
        send_len(16'd0);
        send_tail(8'h00);
        wait_end("t4");
        check_eq("t4_done", 32'(DONE), 32'd1);
        check_eq("t4_nowrite", 32'(n_writes - wr0), 32'd0);

        // Reset in the middle of word 1
        pulse_start();
        send_len(16'd3);
        send_word(0, 32'h1234_5678, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 RST_N = 1'b0;
        #1;
        check_eq("t5_ready", 32'(BYTE_READY), 32'd0);
        check_eq("t5_hold", 32'(CPU_HOLD), 32'd0);
        check_eq("t5_imwa", IMWA, 32'd0);
        check_eq("t5_imwd", IMWD, 32'd0);
        check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        pulse_start();
        send_len(16'd2);
        send_word(0, 32'hDEAD_BEEF, 1);
        send_word(1, 32'h0BAD_F00D, 1);
        send_tail(8'h00);
        wait_end("t5");
        check_eq("t5_done", 32'(DONE), 32'd1);
        check_eq("t5_q_empty2", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
        pulse_start();
        send_len(16'd1);
        send_word(0, 32'h0403_0201, 0);
        check_eq("t6_xor_model", 32'(run_xor), 32'h04);
        send_byte(8'h04, 0);
        wait_end("t6a");
        check_eq("t6_done", 32'(DONE), 32'd1);
        check_eq("t6_err", 32'(ERR), 32'd0);
        pulse_start();
        send_len(16'd1);
        send_word(0, 32'h0403_0201, 0);
        send_byte(8'h05, 0);
        wait_end("t6b");
        check_eq("t6_bad_err", 32'(ERR), 32'd1);
        check_eq("t6_bad_done", 32'(DONE), 32'd0);
        check_eq("t6_bad_hold", 32'(CPU_HOLD), 32'd0);
        check_eq("t6_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
